// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: result-source codes,
// Tnew lookup per stage, bypass-select codes and the "operand unused" tuse.
package hazard_ctrl_pkg;

    localparam logic [2:0] RES_NW  = 3'd0;
    localparam logic [2:0] RES_ALU = 3'd1;
    localparam logic [2:0] RES_DM  = 3'd2;
    localparam logic [2:0] RES_PC  = 3'd3;
    localparam logic [2:0] RES_MD  = 3'd4;
    localparam logic [2:0] RES_CP0 = 3'd5;

    localparam logic [1:0] TNEW_E_ALU   = 2'd1;
    localparam logic [1:0] TNEW_E_DM    = 2'd2;
    localparam logic [1:0] TNEW_E_PC    = 2'd0;
    localparam logic [1:0] TNEW_E_MD    = 2'd1;
    localparam logic [1:0] TNEW_E_CP0   = 2'd2;
    localparam logic [1:0] TNEW_M_DM    = 2'd1;
    localparam logic [1:0] TNEW_M_CP0   = 2'd1;
    localparam logic [1:0] TNEW_M_OTHER = 2'd0;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // Codes 6 and 7 are reserved and behave like "no write".
    function automatic logic is_writer(input logic [2:0] res, input logic [4:0] wa);
        return (res != RES_NW) && (res <= RES_CP0) && (wa != 5'd0);
    endfunction

    function automatic logic [1:0] tnew_e(input logic [2:0] res);
        case (res)
            RES_ALU: return TNEW_E_ALU;
            RES_DM:  return TNEW_E_DM;
            RES_PC:  return TNEW_E_PC;
            RES_MD:  return TNEW_E_MD;
            RES_CP0: return TNEW_E_CP0;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] tnew_m(input logic [2:0] res);
        case (res)
            RES_DM:  return TNEW_M_DM;
            RES_CP0: return TNEW_M_CP0;
            default: return TNEW_M_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// Multiply/divide busy counter: loads the operation latency on a start and
// counts down to zero; a start while busy reloads.
module md_busy_ctr
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic div_i,
    input  logic flush_i,
    output logic busy_o
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] count_q, count_d;

    // A flushed start belongs to a squashed instruction, so it never loads.
    always_comb begin
        count_d = count_q;
        if (start_i && !flush_i) begin
            count_d = div_i ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy_o = (count_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard/forwarding controller. Define HZ_FORWARD_EN to enable
// bypassing; without it every RAW dependency on E/M/W stalls in D.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ra1D,
    input  logic [4:0] ra2D,
    input  logic [1:0] tuse_rsD,
    input  logic [1:0] tuse_rtD,
    input  logic       md_useD,
    input  logic [4:0] ra1E,
    input  logic [4:0] ra2E,
    input  logic [4:0] waE,
    input  logic [2:0] resE,
    input  logic       md_startE,
    input  logic       md_divE,
    input  logic [4:0] ra2M,
    input  logic [4:0] waM,
    input  logic [2:0] resM,
    input  logic [4:0] waW,
    input  logic [2:0] resW,
    input  logic       exc_flush,
    output logic       stall,
    output logic       e_clr,
    output logic [1:0] fwd_rsD,
    output logic [1:0] fwd_rtD,
    output logic [1:0] fwd_rsE,
    output logic [1:0] fwd_rtE,
    output logic       fwd_rtM,
    output logic       md_busy
);

    logic validE, validM, validW;
    logic useRs, useRt;
    logic rawStall, mdStall, ctrBusy;
    logic [1:0] selRsD, selRtD, selRsE, selRtE;
    logic selRtM;

    md_busy_ctr #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy_ctr (
        .clk    (clk),
        .rst    (rst),
        .start_i(md_startE),
        .div_i  (md_divE),
        .flush_i(exc_flush),
        .busy_o (ctrBusy)
    );

    assign validE = is_writer(resE, waE);
    assign validM = is_writer(resM, waM);
    assign validW = is_writer(resW, waW);
    assign useRs  = (ra1D != 5'd0) && (tuse_rsD != TUSE_NONE);
    assign useRt  = (ra2D != 5'd0) && (tuse_rtD != TUSE_NONE);

`ifdef HZ_FORWARD_EN
    logic [1:0] tnewE, tnewM;
    assign tnewE = tnew_e(resE);
    assign tnewM = tnew_m(resM);

    // Stall only when the producer cannot deliver before the consumer needs it.
    always_comb begin
        rawStall = 1'b0;
        if (useRs && ((validE && waE == ra1D && tnewE > tuse_rsD) ||
                      (validM && waM == ra1D && tnewM > tuse_rsD))) begin
            rawStall = 1'b1;
        end
        if (useRt && ((validE && waE == ra2D && tnewE > tuse_rtD) ||
                      (validM && waM == ra2D && tnewM > tuse_rtD))) begin
            rawStall = 1'b1;
        end
    end

    always_comb begin
        selRsD = FWD_RF;
        selRtD = FWD_RF;
        selRsE = FWD_RF;
        selRtE = FWD_RF;
        selRtM = 1'b0;
        if (validE && waE == ra1D && tnewE == 2'd0)      selRsD = FWD_E;
        else if (validM && waM == ra1D && tnewM == 2'd0) selRsD = FWD_M;
        else if (validW && waW == ra1D)                  selRsD = FWD_W;
        if (validE && waE == ra2D && tnewE == 2'd0)      selRtD = FWD_E;
        else if (validM && waM == ra2D && tnewM == 2'd0) selRtD = FWD_M;
        else if (validW && waW == ra2D)                  selRtD = FWD_W;
        if (validM && waM == ra1E && tnewM == 2'd0)      selRsE = FWD_M;
        else if (validW && waW == ra1E)                  selRsE = FWD_W;
        if (validM && waM == ra2E && tnewM == 2'd0)      selRtE = FWD_M;
        else if (validW && waW == ra2E)                  selRtE = FWD_W;
        if (validW && waW == ra2M)                       selRtM = 1'b1;
    end
`else
    logic unused_fwd_tags;
    assign unused_fwd_tags = ^{ra1E, ra2E, ra2M};

    // No bypass network: any in-flight write to a used source must drain first.
    always_comb begin
        rawStall = 1'b0;
        if (useRs && ((validE && waE == ra1D) || (validM && waM == ra1D) ||
                      (validW && waW == ra1D))) begin
            rawStall = 1'b1;
        end
        if (useRt && ((validE && waE == ra2D) || (validM && waM == ra2D) ||
                      (validW && waW == ra2D))) begin
            rawStall = 1'b1;
        end
    end

    assign selRsD = FWD_RF;
    assign selRtD = FWD_RF;
    assign selRsE = FWD_RF;
    assign selRtE = FWD_RF;
    assign selRtM = 1'b0;
`endif

    assign mdStall = md_useD && (md_startE || ctrBusy);

    assign stall   = !rst && (rawStall || mdStall);
    assign e_clr   = stall;
    assign md_busy = !rst && ctrBusy;
    assign fwd_rsD = rst ? FWD_RF : selRsD;
    assign fwd_rtD = rst ? FWD_RF : selRtD;
    assign fwd_rsE = rst ? FWD_RF : selRsE;
    assign fwd_rtE = rst ? FWD_RF : selRtE;
    assign fwd_rtM = !rst && selRtM;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus sequences
// for the mult/div busy counter, flush cancellation and reset behaviour.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [4:0] ra1D, ra2D;
    logic [1:0] tuse_rsD, tuse_rtD;
    logic       md_useD;
    logic [4:0] ra1E, ra2E, waE;
    logic [2:0] resE;
    logic       md_startE, md_divE;
    logic [4:0] ra2M, waM;
    logic [2:0] resM;
    logic [4:0] waW;
    logic [2:0] resW;
    logic       exc_flush;
    logic       stall, e_clr, fwd_rtM, md_busy;
    logic [1:0] fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst(rst),
        .ra1D(ra1D), .ra2D(ra2D), .tuse_rsD(tuse_rsD), .tuse_rtD(tuse_rtD),
        .md_useD(md_useD),
        .ra1E(ra1E), .ra2E(ra2E), .waE(waE), .resE(resE),
        .md_startE(md_startE), .md_divE(md_divE),
        .ra2M(ra2M), .waM(waM), .resM(resM),
        .waW(waW), .resW(resW),
        .exc_flush(exc_flush),
        .stall(stall), .e_clr(e_clr),
        .fwd_rsD(fwd_rsD), .fwd_rtD(fwd_rtD),
        .fwd_rsE(fwd_rsE), .fwd_rtE(fwd_rtE),
        .fwd_rtM(fwd_rtM), .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] ra1D, ra2D;
        logic [1:0] tuRs, tuRt;
        logic [4:0] ra1E, ra2E, waE;
        logic [2:0] resE;
        logic [4:0] ra2M, waM;
        logic [2:0] resM;
        logic [4:0] waW;
        logic [2:0] resW;
        logic       stallF, stallN;
        logic [1:0] fRsD, fRtD, fRsE, fRtE;
        logic       fRtM;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input int a1D, a2D, tRs, tRt, a1E, a2E, wE, rE, a2M, wM, rM, wW, rW,
        input int sF, sN, fsD, ftD, fsE, ftE, ftM);
        vec_t v;
        v.ra1D = 5'(a1D); v.ra2D = 5'(a2D); v.tuRs = 2'(tRs); v.tuRt = 2'(tRt);
        v.ra1E = 5'(a1E); v.ra2E = 5'(a2E); v.waE = 5'(wE); v.resE = 3'(rE);
        v.ra2M = 5'(a2M); v.waM = 5'(wM); v.resM = 3'(rM);
        v.waW = 5'(wW); v.resW = 3'(rW);
        v.stallF = 1'(sF); v.stallN = 1'(sN);
        v.fRsD = 2'(fsD); v.fRtD = 2'(ftD); v.fRsE = 2'(fsE); v.fRtE = 2'(ftE);
        v.fRtM = 1'(ftM);
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        ra1D = '0; ra2D = '0; tuse_rsD = TUSE_NONE; tuse_rtD = TUSE_NONE;
        md_useD = 1'b0; ra1E = '0; ra2E = '0; waE = '0; resE = RES_NW;
        md_startE = 1'b0; md_divE = 1'b0; ra2M = '0; waM = '0; resM = RES_NW;
        waW = '0; resW = RES_NW; exc_flush = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        ra1D = v.ra1D; ra2D = v.ra2D; tuse_rsD = v.tuRs; tuse_rtD = v.tuRt;
        ra1E = v.ra1E; ra2E = v.ra2E; waE = v.waE; resE = v.resE;
        ra2M = v.ra2M; waM = v.waM; resM = v.resM; waW = v.waW; resW = v.resW;
        md_useD = 1'b0; md_startE = 1'b0; md_divE = 1'b0; exc_flush = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic eStall;
        logic [1:0] eRsD, eRtD, eRsE, eRtE;
        logic eRtM;

        //        ra1D ra2D tRs tRt ra1E ra2E waE resE ra2M waM resM waW resW  sF sN  fsD ftD fsE ftE ftM
        vecs.push_back(mk( 1, 0, 1, 3,  0, 0,  1, 2,  0, 0, 0,  0, 0,  1, 1,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 1, 0, 1, 3,  0, 0,  0, 0,  0, 1, 2,  0, 0,  0, 1,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 0, 0, 3, 3,  1, 0,  0, 0,  0, 0, 0,  1, 2,  0, 0,  0, 0, 3, 0, 0));
        vecs.push_back(mk( 3, 4, 0, 0,  0, 0,  0, 0,  0, 3, 1,  0, 0,  0, 1,  2, 0, 0, 0, 0));
        vecs.push_back(mk(31, 0, 0, 3,  0, 0, 31, 3,  0, 0, 0,  0, 0,  0, 1,  1, 0, 0, 0, 0));
        vecs.push_back(mk( 0, 0, 0, 0,  0, 0,  0, 1,  0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 0, 5, 3, 0,  0, 0,  5, 1,  0, 0, 0,  0, 0,  1, 1,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 5, 0, 1, 3,  0, 0,  5, 1,  0, 0, 0,  0, 0,  0, 1,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 7, 0, 1, 3,  0, 0,  7, 5,  0, 0, 0,  0, 0,  1, 1,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 0, 0, 3, 3,  8, 9,  0, 0,  9, 8, 1,  9, 4,  0, 0,  0, 0, 2, 3, 1));
        vecs.push_back(mk( 0, 0, 3, 3,  8, 0,  0, 0,  0, 8, 6,  8, 1,  0, 0,  0, 0, 3, 0, 0));
        vecs.push_back(mk( 5, 0, 3, 3,  0, 0,  5, 2,  0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 0, 2, 3, 0,  0, 0,  0, 0,  0, 0, 0,  2, 2,  0, 1,  0, 3, 0, 0, 0));
        vecs.push_back(mk( 4, 0, 0, 3,  0, 0,  4, 0,  0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk( 6, 0, 0, 3,  0, 0,  0, 0,  0, 6, 5,  0, 0,  1, 1,  0, 0, 0, 0, 0));
        vecs.push_back(mk(10, 0, 2, 3,  0, 0, 10, 3,  0,10, 1, 10, 1,  0, 1,  1, 0, 0, 0, 0));

        // Reset with a jal->jr dependency, mfhi in D and a mult start: all outputs 0.
        clearInputs();
        rst = 1'b1;
        ra1D = 5'd31; tuse_rsD = 2'd0; waE = 5'd31; resE = RES_PC;
        md_useD = 1'b1; md_startE = 1'b1;
        nextCycle();
        checkOutput("rst_stall", int'(stall), 0);
        checkOutput("rst_e_clr", int'(e_clr), 0);
        checkOutput("rst_fwd_rsD", int'(fwd_rsD), 0);
        checkOutput("rst_md_busy", int'(md_busy), 0);
        nextCycle();
        clearInputs();
        rst = 1'b0;
        #1;
        checkOutput("rst_start_no_load", int'(md_busy), 0);
        nextCycle();

        foreach (vecs[i]) begin
            v = vecs[i];
            applyStimulus(v);
`ifdef HZ_FORWARD_EN
            eStall = v.stallF; eRsD = v.fRsD; eRtD = v.fRtD;
            eRsE = v.fRsE; eRtE = v.fRtE; eRtM = v.fRtM;
`else
            eStall = v.stallN; eRsD = 2'd0; eRtD = 2'd0;
            eRsE = 2'd0; eRtE = 2'd0; eRtM = 1'b0;
`endif
            #2;
            checkOutput($sformatf("v%0d_stall", i), int'(stall), int'(eStall));
            checkOutput($sformatf("v%0d_e_clr", i), int'(e_clr), int'(eStall));
            checkOutput($sformatf("v%0d_fwd_rsD", i), int'(fwd_rsD), int'(eRsD));
            checkOutput($sformatf("v%0d_fwd_rtD", i), int'(fwd_rtD), int'(eRtD));
            checkOutput($sformatf("v%0d_fwd_rsE", i), int'(fwd_rsE), int'(eRsE));
            checkOutput($sformatf("v%0d_fwd_rtE", i), int'(fwd_rtE), int'(eRtE));
            checkOutput($sformatf("v%0d_fwd_rtM", i), int'(fwd_rtM), int'(eRtM));
            nextCycle();
        end

        // Divide start at t with mflo in D: stall t..t+10, released at t+11.
        clearInputs();
        md_useD = 1'b1; md_startE = 1'b1; md_divE = 1'b1;
        #1;
        checkOutput("div_t_stall", int'(stall), 1);
        checkOutput("div_t_busy", int'(md_busy), 0);
        nextCycle();
        md_startE = 1'b0; md_divE = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            #1;
            checkOutput($sformatf("div_t+%0d_busy", k), int'(md_busy), (k <= 10) ? 1 : 0);
            checkOutput($sformatf("div_t+%0d_stall", k), int'(stall), (k <= 10) ? 1 : 0);
            nextCycle();
        end

        // Divide start cancelled by an exception flush in the same cycle.
        clearInputs();
        md_useD = 1'b1; md_startE = 1'b1; md_divE = 1'b1; exc_flush = 1'b1;
        #1;
        checkOutput("flush_t_stall", int'(stall), 1);
        nextCycle();
        md_startE = 1'b0; md_divE = 1'b0; exc_flush = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            #1;
            checkOutput($sformatf("flush_t+%0d_busy", k), int'(md_busy), 0);
            checkOutput($sformatf("flush_t+%0d_stall", k), int'(stall), 0);
            nextCycle();
        end

        // Multiply: busy t+1..t+5; a flushed restart at t+2 must not reload.
        clearInputs();
        md_startE = 1'b1;
        nextCycle();
        md_startE = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 2) begin
                md_startE = 1'b1; md_divE = 1'b1; exc_flush = 1'b1;
            end else begin
                md_startE = 1'b0; md_divE = 1'b0; exc_flush = 1'b0;
            end
            #1;
            checkOutput($sformatf("mult_t+%0d_busy", k), int'(md_busy), (k <= 5) ? 1 : 0);
            nextCycle();
        end

        // Counter at 3, then reset while a RAW hazard is present.
        clearInputs();
        md_startE = 1'b1;
        nextCycle();
        md_startE = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("ctr3_busy", int'(md_busy), 1);
        rst = 1'b1;
        ra1D = 5'd1; tuse_rsD = 2'd1; waE = 5'd1; resE = RES_DM;
        #1;
        checkOutput("rst_raw_stall", int'(stall), 0);
        checkOutput("rst_raw_busy", int'(md_busy), 0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("post_rst_busy", int'(md_busy), 0);
        checkOutput("post_rst_stall", int'(stall), 1);
        nextCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
